// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised Moore sequence detector.
// Next-state function implements KMP-style prefix fallback over the pattern.
package seq_det_pkg;

    localparam int unsigned MAX_PAT_W   = 16;
    localparam int unsigned MAX_STATE_W = $clog2(MAX_PAT_W + 1);

    // Longest pattern prefix that is a suffix of (matched prefix of length s, then b).
    function automatic int seq_next_state(input logic [15:0] pattern, input int pat_w,
                                          input int s, input logic b, input logic overlap);
        logic [16:0] seq;
        int          len;
        int          best;
        logic        ok;
        if (s >= pat_w && !overlap) begin
            return (b == pattern[pat_w-1]) ? 1 : 0;
        end
        seq = '0;
        for (int j = 0; j < 17; j++) begin
            if (j < s) begin
                seq[j] = pattern[pat_w-1-j];
            end else if (j == s) begin
                seq[j] = b;
            end
        end
        len  = s + 1;
        best = 0;
        for (int k = 1; k <= 16; k++) begin
            ok = (k <= len) && (k <= pat_w);
            for (int i = 0; i < 16; i++) begin
                if (ok && i < k) begin
                    if (pattern[pat_w-1-i] != seq[len-k+i]) begin
                        ok = 1'b0;
                    end
                end
            end
            if (ok) begin
                best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector with valid qualification and match counter.
// Define SEQ_DET_MEALY_EN to add the combinational one-cycle-early flag y_early.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned             PAT_W   = 3,
    parameter logic [PAT_W-1:0]        PATTERN = 3'b110,
    parameter int unsigned             OVERLAP = 1,
    parameter int unsigned             CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in,
    input  logic                         clr_cnt,
    output logic                         y,
`ifdef SEQ_DET_MEALY_EN
    output logic                         y_early,
`endif
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PAT_W+1)-1:0]   state_o
);

    localparam int unsigned     ST_W   = $clog2(PAT_W + 1);
    localparam logic [ST_W-1:0] DET_ST = ST_W'(PAT_W);

    if (PAT_W < 2 || PAT_W > MAX_PAT_W || CNT_W < 1) begin : g_param_check
        $fatal(1, "seq_detector_param: PAT_W must be 2..16 and CNT_W >= 1");
    end

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    logic            detect;

    always_comb begin
        state_d = state_q;
        detect  = 1'b0;
        if (in_valid) begin
            state_d = ST_W'(seq_next_state(16'(PATTERN), int'(PAT_W), int'(state_q), in,
                                           OVERLAP != 0));
            detect  = (state_d == DET_ST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign y       = (state_q == DET_ST);
    assign state_o = state_q;

`ifdef SEQ_DET_MEALY_EN
    assign y_early = ~reset & detect;
`endif

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (detect),
        .clr   (clr_cnt),
        .cnt   (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: six detector configurations share one stimulus stream.
module tb_seq_detector_param;

    localparam int NI = 6;
    localparam int          PWA [NI] = '{3, 4, 4, 3, 3, 3};
    localparam logic [15:0] PTA [NI] = '{16'h6, 16'hB, 16'hB, 16'h7, 16'h7, 16'h6};
    localparam int          OVA [NI] = '{1, 1, 0, 1, 0, 1};
    localparam int          CWA [NI] = '{8, 8, 8, 8, 8, 2};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in = 1'b0;
    logic clr_cnt = 1'b0;

    logic [4:0] st_a  [NI];
    logic       y_a   [NI];
    logic [7:0] cnt_a [NI];
`ifdef SEQ_DET_MEALY_EN
    logic       ye_a  [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int SW = $clog2(PWA[g] + 1);
        logic [SW-1:0]     st;
        logic [CWA[g]-1:0] cnt;
        logic              yv;
`ifdef SEQ_DET_MEALY_EN
        logic              ye;
        assign ye_a[g] = ye;
`endif
        seq_detector_param #(
            .PAT_W   (PWA[g]),
            .PATTERN (PTA[g][PWA[g]-1:0]),
            .OVERLAP (OVA[g]),
            .CNT_W   (CWA[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in        (in),
            .clr_cnt   (clr_cnt),
            .y         (yv),
`ifdef SEQ_DET_MEALY_EN
            .y_early   (ye),
`endif
            .match_cnt (cnt),
            .state_o   (st)
        );
        assign st_a[g]  = 5'(st);
        assign cnt_a[g] = 8'(cnt);
        assign y_a[g]   = yv;
    end

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // kind 0: registered outputs after the edge; kind 1: y_early during the drive cycle
    typedef struct {
        int kind;
        int cyc;
        int inst;
        int st;
        int cnt;
    } rec_t;

    rec_t q[$];
    rec_t mon_r;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, inst, cycle, act,
                     exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            mon_r = q.pop_front();
            if (mon_r.kind == 0) begin
                check("state_o", mon_r.inst, int'(st_a[mon_r.inst]), mon_r.st);
                check("y", mon_r.inst, int'(y_a[mon_r.inst]),
                      (mon_r.st == PWA[mon_r.inst]) ? 1 : 0);
                check("match_cnt", mon_r.inst, int'(cnt_a[mon_r.inst]), mon_r.cnt);
            end else begin
`ifdef SEQ_DET_MEALY_EN
                check("y_early", mon_r.inst, int'(ye_a[mon_r.inst]), mon_r.st);
`endif
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic b, input logic c);
        @(posedge clk);
        #1;
        reset    = r;
        in_valid = v;
        in       = b;
        clr_cnt  = c;
    endtask

    task automatic expect_regs(input int inst, input int st, input int cnt);
        q.push_back('{kind: 0, cyc: cycle + 1, inst: inst, st: st, cnt: cnt});
    endtask

    task automatic expect_early(input int inst, input int ye);
`ifdef SEQ_DET_MEALY_EN
        q.push_back('{kind: 1, cyc: cycle, inst: inst, st: ye, cnt: 0});
`endif
    endtask

    // Reset with valid/clear asserted to show reset overrides both
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            for (int k = 0; k < NI; k++) begin
                expect_regs(k, 0, 0);
                expect_early(k, 0);
            end
        end
    endtask

    task automatic run_stream(input int inst, input int nb, input logic [15:0] bits,
                              input int sts [16], input int cnts [16]);
        for (int i = 0; i < nb; i++) begin
            step(1'b0, 1'b1, bits[i], 1'b0);
            expect_regs(inst, sts[i], cnts[i]);
            expect_early(inst, (sts[i] == PWA[inst]) ? 1 : 0);
        end
    endtask

    int sts_a [16];
    int cnt_e [16];
    int sts_b [16];
    int cnt_f [16];
    logic [15:0] bits;

    initial begin
        do_reset(2);

        // 110 overlapping: 1,1,0,1,1,0,1,1 (bits listed LSB-first as sent)
        bits  = 16'b0000_0000_1101_1011;
        sts_a = '{1, 2, 3, 1, 2, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        cnt_e = '{0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        run_stream(0, 8, bits, sts_a, cnt_e);

        // 1011 overlapping vs non-overlapping: 1,0,1,1,0,1,1
        do_reset(1);
        bits  = 16'b0000_0000_0110_1101;
        sts_a = '{1, 2, 3, 4, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        cnt_e = '{0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        sts_b = '{1, 2, 3, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        cnt_f = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, bits[i], 1'b0);
            expect_regs(1, sts_a[i], cnt_e[i]);
            expect_regs(2, sts_b[i], cnt_f[i]);
            expect_early(1, (sts_a[i] == 4) ? 1 : 0);
            expect_early(2, (sts_b[i] == 4) ? 1 : 0);
        end

        // 111 with six ones
        do_reset(1);
        sts_a = '{1, 2, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        cnt_e = '{0, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        sts_b = '{1, 2, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        cnt_f = '{0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            expect_regs(3, sts_a[i], cnt_e[i]);
            expect_regs(4, sts_b[i], cnt_f[i]);
            expect_early(3, (sts_a[i] == 3) ? 1 : 0);
            expect_early(4, (sts_b[i] == 3) ? 1 : 0);
        end

        // in_valid gap holds state, then detect, then y holds during idle
        do_reset(1);
        step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(0, 1, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0], 1'b0);
            expect_regs(0, 2, 0);
            expect_early(0, 0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0); expect_regs(0, 3, 1); expect_early(0, 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, ~i[0], 1'b0);
            expect_regs(0, 3, 1);
            expect_early(0, 0);
        end

        // CNT_W=2 saturation over five detections, then clear beats a detection
        do_reset(1);
        for (int r = 0; r < 5; r++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(5, 1, (r < 3) ? r : 3);
            step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(5, 2, (r < 3) ? r : 3);
            step(1'b0, 1'b1, 1'b0, 1'b0); expect_regs(5, 3, (r + 1 < 3) ? r + 1 : 3);
            expect_early(5, 1);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(5, 1, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(5, 2, 3);
        step(1'b0, 1'b1, 1'b0, 1'b1); expect_regs(5, 3, 0); expect_early(5, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(5, 1, 0);

        // Reset mid-pattern discards the partial match
        do_reset(1);
        step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(0, 1, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0); expect_regs(0, 2, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0); expect_regs(0, 0, 0); expect_early(0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0); expect_regs(0, 0, 0); expect_early(0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0); expect_regs(0, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
